ham_serial_rx: RTL and testbench
================================

# ham_serial_rx

Serial front end for the (7,4) Hamming receive path. Shifts in codeword bits one per qualified cycle, LSB first, and frames them into 7-bit codewords. Buffers complete codewords in a small FIFO and presents them over a valid/ready handshake to the combinational Hamming decoder directly downstream. Flags framing errors and buffer overruns, and keeps a saturating count of dropped codewords.

## Interface
- `DEPTH`, default 2: codeword FIFO entries; legal values are powers of two, 2 or greater.
- `clk` input 1: single clock; all flops update on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ser_in` input 1: serial data bit.
- `ser_valid` input 1: `ser_in` is sampled on this cycle.
- `sof` input 1: qualified by `ser_valid`; marks the current bit as bit 0 of a new codeword.
- `ham_code` output 7: head-of-FIFO codeword; bit i is the i-th received bit.
- `code_valid` output 1: FIFO not empty.
- `code_ready` input 1: consumer accepts `ham_code` this cycle.
- `frame_err` output 1: one-cycle pulse; a partial codeword was discarded.
- `overrun` output 1: one-cycle pulse; a complete codeword was dropped because the FIFO was full.
- `drop_cnt` output 8: saturating count of dropped codewords; saturates at 255.

## Operation
- Framer FSM has two states, IDLE and SHIFT, with a 3-bit bit index `idx` and a 7-bit shift register.
- **IDLE**
  - `ser_valid && sof`: store `ser_in` at bit 0, set `idx` = 1, go to SHIFT.
  - `ser_valid && !sof`: bit ignored, no flag raised.
- **SHIFT, `ser_valid && !sof`**
  - Store `ser_in` at bit `idx`.
  - If `idx` = 6, the codeword is complete: push it to the FIFO and go to IDLE. Otherwise increment `idx`.
- **SHIFT, `ser_valid && sof`**
  - Pulse `frame_err`.
  - Discard the partial word and restart: bit 0 = `ser_in`, `idx` = 1, stay in SHIFT.
- **SHIFT, `!ser_valid`**: hold state; there is no timeout.
- **Push to a FIFO that is not full**: the word is written.
- **Push to a full FIFO**
  - If `code_valid && code_ready` in the same cycle: the pop frees a slot and the push succeeds, so no overrun.
  - Otherwise: drop the word, pulse `overrun`, and increment `drop_cnt` unless it is at 255.
- **Pop**: occurs when `code_valid && code_ready`. `code_ready` while empty has no effect.
- **Simultaneous push and pop on an empty FIFO**: the word is written and becomes visible the next cycle; there is no bypass.
- **Order**: words leave the FIFO in the order they were pushed; read and write pointers wrap modulo `DEPTH`.
- **`ham_code` stability**: `ham_code` is stable while `code_valid && !code_ready`.

## Timing
- **Reset**: asserting `rst_n` low clears everything asynchronously.
  - FSM goes to IDLE; `idx`, the shift register, the FIFO pointers and the occupancy count all clear to 0.
  - Outputs: `ham_code` = 0, `code_valid` = 0, `frame_err` = 0, `overrun` = 0, `drop_cnt` = 0.
- **Reset mid-frame**: the partial word is lost and no flag is raised.
- **Reset release**: the first `sof` bit may arrive on the first edge after `rst_n` rises.
- **Latency**: with bit 6 sampled on edge N and the FIFO empty, `code_valid` = 1 and `ham_code` is valid after edge N.
- **Throughput**: one codeword every 7 qualified cycles. Back-to-back frames are allowed, with the next `sof` on the cycle right after bit 6.
- **Flag timing**: `frame_err` and `overrun` are registered; each is high for exactly the cycle following the causing edge.
- **`drop_cnt`**: updates on the same edge that produces its `overrun` pulse.

## Test plan
- **Single codeword**: `DEPTH` = 2, consumer ready. Drive `sof` then bits 1,0,1,1,0,0,1 (bit 0 first) on consecutive cycles → `ham_code` = 7'b1001101. `code_valid` is high for one cycle, starting the cycle after bit 6.
- **Back-to-back with gaps**: send 7'h55 then 7'h2A with random `ser_valid` gaps and `code_ready` held at 0 → FIFO holds both words. Raising `code_ready` yields 7'h55 then 7'h2A, after which `code_valid` = 0.
- **Framing error**: `sof` plus 3 bits, then a new `sof` with 7'h7F → exactly one `frame_err` pulse and only 7'h7F delivered.
- **Overrun**: `code_ready` = 0; send 3 words → third word dropped, one `overrun` pulse, `drop_cnt` = 1. Repeat 300 drops → `drop_cnt` = 255.
- **Full with simultaneous pop**: FIFO full; bit 6 of a third word is sampled in the same cycle as a pop → no `overrun`, and all three words are delivered in order.
- **Reset mid-frame**: assert `rst_n` low after 4 bits of a frame while 1 word is buffered → all outputs 0. After release, a fresh frame of 7'h33 is delivered with no `frame_err`.

Source files
------------

// File: rtl/ham_serial_rx.sv
// rtl/ham_serial_rx.sv - serial framer and codeword FIFO for the (7,4) Hamming receive path
module ham_serial_rx #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_valid,
    input  logic       sof,
    output logic [6:0] ham_code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [6:0]    shreg;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic          push_req;
    logic          pop;
    logic          full;
    logic          do_push;
    logic          drop;
    logic [6:0]    push_word;

    // The final bit goes straight into the pushed word, so the FIFO write
    // lands on the same edge that samples bit 6.
    assign push_req   = (state == SHIFT) && ser_valid && !sof && (idx == 3'd6);
    assign push_word  = {ser_in, shreg[5:0]};
    assign code_valid = (count != '0);
    assign full       = (count == CNT_FULL);
    assign pop        = code_valid && code_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    assign do_push    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign ham_code   = mem[rptr];

    // Framer FSM: bit assembly, restart on sof, registered error/overrun pulses and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (ser_valid) begin
                if (sof) begin
                    frame_err <= (state == SHIFT);
                    shreg     <= {6'b0, ser_in};
                    idx       <= 3'd1;
                    state     <= SHIFT;
                end else if (state == SHIFT) begin
                    shreg[idx] <= ser_in;
                    if (idx == 3'd6) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            end
        end
    end

    // Codeword FIFO: power-of-two depth, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= push_word;
                wptr      <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (do_push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ham_serial_rx.sv
// tb/tb_ham_serial_rx.sv - self-checking bench for ham_serial_rx
module tb_ham_serial_rx;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       sof = 1'b0;
    logic       code_ready = 1'b0;
    logic [6:0] ham_code;
    logic       code_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position, partial word, buffered words, counters.
    logic [6:0] m_fifo[$];
    logic [6:0] exp_got[$];
    logic [6:0] got_q[$];
    logic [6:0] m_buf;
    int         m_pos = -1;
    int         m_drop = 0;
    int         m_fe = 0;
    int         m_ov = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;

    ham_serial_rx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .sof        (sof),
        .ham_code   (ham_code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, advance the model, record what the DUT emits.
    task automatic step(input logic v, input logic s, input logic b);
        logic       pop_now;
        logic       push_now;
        ser_valid = v;
        sof       = s;
        ser_in    = b;
        if (code_valid && code_ready) got_q.push_back(ham_code);
        pop_now  = code_ready && (m_fifo.size() > 0);
        push_now = 1'b0;
        if (v) begin
            if (s) begin
                if (m_pos >= 0) m_fe++;
                m_buf    = 7'd0;
                m_buf[0] = b;
                m_pos    = 1;
            end else if (m_pos >= 0) begin
                m_buf[m_pos] = b;
                if (m_pos == 6) begin
                    push_now = 1'b1;
                    m_pos    = -1;
                end else begin
                    m_pos++;
                end
            end
        end
        if (pop_now) exp_got.push_back(m_fifo.pop_front());
        if (push_now) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(m_buf);
            end else begin
                m_ov++;
                if (m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
    endtask

    task automatic send_word(input logic [6:0] w, input int max_gap);
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, max_gap)) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
            step(1'b1, (i == 0), w[i]);
        end
    endtask

    task automatic drain();
        code_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH + 4 && (m_fifo.size() > 0 || code_valid); k++) begin
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_model();
        m_fifo.delete();
        exp_got.delete();
        got_q.delete();
        m_pos   = -1;
        m_drop  = 0;
        m_fe    = 0;
        m_ov    = 0;
        fe_seen = 0;
        ov_seen = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        ser_valid  = 1'b0;
        sof        = 1'b0;
        ser_in     = 1'b0;
        code_ready = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (ham_code !== 7'd0) begin errors++; $display("FAIL reset_ham_code got %h exp 00", ham_code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid got %b exp 0", code_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_single();
        logic [6:0] bits;
        apply_reset();
        code_ready = 1'b1;
        bits = 7'b1001101;
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0), bits[i]);
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", code_valid); end
        step(1'b1, 1'b0, bits[6]);
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", code_valid); end
        checks++; if (ham_code !== 7'b1001101) begin errors++; $display("FAIL single_code got %b exp 1001101", ham_code); end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b exp 0", code_valid); end
        checks++; if (got_q.size() !== 1 || got_q[0] !== 7'h4D) begin errors++; $display("FAIL single_delivered got %p exp 4d", got_q); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        code_ready = 1'b0;
        send_word(7'h55, 3);
        send_word(7'h2A, 3);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++; if (code_valid !== 1'b1 || ham_code !== 7'h55) begin errors++; $display("FAIL b2b_hold got v=%b %h exp v=1 55", code_valid, ham_code); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL b2b_no_pop got %0d exp 0", got_q.size()); end
        drain();
        checks++; if (got_q.size() !== 2 || got_q[0] !== 7'h55 || got_q[1] !== 7'h2A) begin errors++; $display("FAIL b2b_order got %p exp 55 2a", got_q); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", code_valid); end
    endtask

    task automatic test_frame_err();
        apply_reset();
        code_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        send_word(7'h7F, 0);
        drain();
        checks++; if (fe_seen !== 1) begin errors++; $display("FAIL frame_err_pulses got %0d exp 1", fe_seen); end
        checks++; if (got_q.size() !== 1 || got_q[0] !== 7'h7F) begin errors++; $display("FAIL frame_err_words got %p exp 7f", got_q); end
    endtask

    task automatic test_overrun();
        logic [6:0] w0;
        logic [6:0] w1;
        apply_reset();
        code_ready = 1'b0;
        w0 = 7'($urandom);
        w1 = 7'($urandom);
        send_word(w0, 2);
        send_word(w1, 2);
        send_word(7'($urandom), 2);
        checks++; if (ov_seen !== 1) begin errors++; $display("FAIL overrun_pulse got %0d exp 1", ov_seen); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL overrun_cnt got %0d exp 1", drop_cnt); end
        for (int n = 0; n < 300; n++) send_word(7'($urandom), 0);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL overrun_sat got %0d exp 255", drop_cnt); end
        checks++; if (ov_seen !== 301) begin errors++; $display("FAIL overrun_pulses got %0d exp 301", ov_seen); end
        drain();
        checks++; if (got_q.size() !== 2 || got_q[0] !== w0 || got_q[1] !== w1) begin errors++; $display("FAIL overrun_kept got %p exp %h %h", got_q, w0, w1); end
    endtask

    task automatic test_full_pop();
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] c;
        apply_reset();
        code_ready = 1'b0;
        a = 7'($urandom);
        b = 7'($urandom);
        c = 7'($urandom);
        send_word(a, 1);
        send_word(b, 1);
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0), c[i]);
        code_ready = 1'b1;
        step(1'b1, 1'b0, c[6]);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pop_overrun got %b exp 0", overrun); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL full_pop_cnt got %0d exp 0", drop_cnt); end
        drain();
        checks++; if (got_q.size() !== 3 || got_q[0] !== a || got_q[1] !== b || got_q[2] !== c) begin errors++; $display("FAIL full_pop_order got %p exp %h %h %h", got_q, a, b, c); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        code_ready = 1'b0;
        send_word(7'h5A, 1);
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        checks++; if (ham_code !== 7'd0) begin errors++; $display("FAIL mid_rst_code got %h exp 00", ham_code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", code_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_flags got %b %b %0d exp 0 0 0", frame_err, overrun, drop_cnt); end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        code_ready = 1'b1;
        send_word(7'h33, 0);
        drain();
        checks++; if (fe_seen !== 0) begin errors++; $display("FAIL mid_rst_frame_err got %0d exp 0", fe_seen); end
        checks++; if (got_q.size() !== 1 || got_q[0] !== 7'h33) begin errors++; $display("FAIL mid_rst_word got %p exp 33", got_q); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            code_ready = 1'($urandom % 2);
            step(($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom % 2));
        end
        drain();
        checks++; if (got_q.size() !== exp_got.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_got.size()); end
        for (int i = 0; i < got_q.size() && i < exp_got.size(); i++) begin
            checks++; if (got_q[i] !== exp_got[i]) begin errors++; $display("FAIL rand_word[%0d] got %h exp %h", i, got_q[i], exp_got[i]); end
        end
        checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop_cnt got %0d exp %0d", drop_cnt, m_drop); end
        checks++; if (fe_seen !== m_fe) begin errors++; $display("FAIL rand_frame_err got %0d exp %0d", fe_seen, m_fe); end
        checks++; if (ov_seen !== m_ov) begin errors++; $display("FAIL rand_overrun got %0d exp %0d", ov_seen, m_ov); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
